// File: rtl/f1_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : f1_light_sequencer
// Brief    : F1 start-light sequencer. Lamps light one per STEP_MS ticks,
//            all lamps hold for a random LFSR delay, then blank with time_out.
// Revision : 1.0  initial release
// ============================================================================
module f1_light_sequencer #(
    parameter int N_LIGHTS = 8,
    parameter int STEP_MS  = 500,
    parameter int K_WIDTH  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                tick,
    input  logic [K_WIDTH-1:0]  prbs,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                time_out,
    output logic                busy
);

    localparam int                  c_STEP_W      = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_RELOAD = c_STEP_W'(STEP_MS - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_ONE    = c_STEP_W'(1);
    localparam logic [K_WIDTH-1:0]  c_DELAY_ONE   = K_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LIGHT = 2'd1;
    localparam logic [1:0] c_DELAY = 2'd2;

    logic [1:0]          r_state;
    logic                r_trigger_q;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [K_WIDTH-1:0]  r_delay_cnt;
    logic [N_LIGHTS-1:0] r_data;
    logic                r_lfsr_en;
    logic                r_time_out;
    logic                r_busy;

    logic                w_trig_rise;
    logic [N_LIGHTS-1:0] w_shifted;

    assign w_trig_rise = trigger & ~r_trigger_q;
    assign w_shifted   = {r_data[N_LIGHTS-2:0], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_trigger_q <= 1'b0;
            r_step_cnt  <= '0;
            r_delay_cnt <= '0;
            r_data      <= '0;
            r_lfsr_en   <= 1'b1;
            r_time_out  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_trigger_q <= trigger;
            r_time_out  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_data    <= '0;
                    r_lfsr_en <= 1'b1;
                    r_busy    <= 1'b0;
                    // A tick coinciding with the start edge is deliberately not counted.
                    if (w_trig_rise) begin
                        r_state    <= c_LIGHT;
                        r_data     <= {{(N_LIGHTS-1){1'b0}}, 1'b1};
                        r_step_cnt <= c_STEP_RELOAD;
                        r_busy     <= 1'b1;
                    end
                end
                c_LIGHT: begin
                    r_lfsr_en <= 1'b1;
                    if (tick) begin
                        if (r_step_cnt != '0) begin
                            r_step_cnt <= r_step_cnt - c_STEP_ONE;
                        end else begin
                            r_data     <= w_shifted;
                            r_step_cnt <= c_STEP_RELOAD;
                            // Latch the delay and freeze the LFSR on the edge the last lamp lights.
                            if (&w_shifted) begin
                                r_state     <= c_DELAY;
                                r_delay_cnt <= prbs;
                                r_lfsr_en   <= 1'b0;
                            end
                        end
                    end
                end
                c_DELAY: begin
                    r_lfsr_en <= 1'b0;
                    r_data    <= '1;
                    if (tick) begin
                        // A latched delay of zero behaves as one tick.
                        if (r_delay_cnt <= c_DELAY_ONE) begin
                            r_state    <= c_IDLE;
                            r_data     <= '0;
                            r_time_out <= 1'b1;
                            r_lfsr_en  <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_delay_cnt <= r_delay_cnt - c_DELAY_ONE;
                        end
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_step_cnt  <= '0;
                    r_delay_cnt <= '0;
                    r_data      <= '0;
                    r_lfsr_en   <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign lfsr_en  = r_lfsr_en;
    assign data_out = r_data;
    assign time_out = r_time_out;
    assign busy     = r_busy;

endmodule
`default_nettype wire
